// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage ALU control and the multiply/divide sequencer.
package alu_ctrl_pkg;

  localparam logic [1:0] ALU_OP_MEM  = 2'b00;
  localparam logic [1:0] ALU_OP_BR   = 2'b01;
  localparam logic [1:0] ALU_OP_R    = 2'b10;
  localparam logic [1:0] ALU_OP_SLTI = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Functs that touch HI/LO and therefore must wait for a busy sequencer.
  function automatic logic is_md_funct(input logic [5:0] fn);
    return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide on unsigned magnitudes.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] opnd_b;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Multiply: acc_lo holds the multiplier and shifts right as product bits fill in from acc_hi.
  // Divide: acc_lo holds the dividend, shifts left into the remainder, quotient bits fill from the right.
  always_comb begin
    mul_addend = acc_lo[0] ? opnd_b : '0;
    mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opnd_b};
  end

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      count  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= load_lo;
      opnd_b <= load_b;
      count  <= '0;
    end else if (step) begin
      count <= count + 1'b1;
      if (div_mode) begin
        // A set top bit of the difference means the trial subtract went negative: restore.
        if (div_diff[WIDTH]) begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end else begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// Execute-stage ALU control decode plus a multi-cycle mult/div sequencer owning HI/LO.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ENABLE_MD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       function_bits,
  input  logic             instr_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       alu_operation,
  output logic             is_jr,
  output logic             stall,
  output logic [WIDTH-1:0] mf_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        dbg_state
);

  localparam bit MD_ON = (ENABLE_MD != 0);

  md_state_e        state, next_state;
  logic             r_type, fn_mul, fn_div, fn_signed, accept;
  logic [WIDTH-1:0] abs_a, abs_b, load_lo, load_b;
  logic             neg_q, neg_r, div0, op_div;
  logic             core_load, core_step, core_clear, core_div, core_last, write_hilo;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;

  always_comb begin
    alu_operation = ALU_AND;
    is_jr         = 1'b0;
    case (alu_op)
      ALU_OP_MEM:  alu_operation = ALU_ADD;
      ALU_OP_BR:   alu_operation = ALU_SUB;
      ALU_OP_SLTI: alu_operation = ALU_SLT;
      default: begin
        case (function_bits)
          FN_ADD: alu_operation = ALU_ADD;
          FN_SUB: alu_operation = ALU_SUB;
          FN_AND: alu_operation = ALU_AND;
          FN_OR:  alu_operation = ALU_OR;
          FN_SLT: alu_operation = ALU_SLT;
          FN_JR: begin
            alu_operation = ALU_SLT;
            is_jr         = 1'b1;
          end
          default: alu_operation = ALU_AND;
        endcase
      end
    endcase
  end

  assign r_type    = (alu_op == ALU_OP_R);
  assign fn_mul    = (function_bits == FN_MULT) || (function_bits == FN_MULTU);
  assign fn_div    = (function_bits == FN_DIV)  || (function_bits == FN_DIVU);
  assign fn_signed = (function_bits == FN_MULT) || (function_bits == FN_DIV);

  // Pipeline handshake: instr_valid marks a live instruction in execute; it advances on any
  // edge where stall is 0. An md op is taken the cycle it is valid in IDLE (never stalled itself);
  // a later HI/LO user while the sequencer is busy sees stall=1 until the result is in HI/LO.
  assign accept = MD_ON && (state == ST_IDLE) && instr_valid && !flush && r_type && (fn_mul || fn_div);
  assign stall  = MD_ON && (state != ST_IDLE) && instr_valid && r_type && is_md_funct(function_bits);

  assign abs_a   = (fn_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b   = (fn_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  assign load_lo = fn_div ? abs_a : abs_b;
  assign load_b  = fn_div ? abs_b : abs_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_div   = 1'b0;
    write_hilo = 1'b0;
    core_clear = flush;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          core_load  = 1'b1;
          next_state = fn_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        core_step = !flush;
        core_div  = (state == ST_DIV);
        if (core_last) next_state = ST_FIX;
      end
      ST_FIX: begin
        write_hilo = !flush;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (flush) next_state = ST_IDLE;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      op_div <= 1'b0;
    end else if (accept) begin
      op_div <= fn_div;
      neg_q  <= fn_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r  <= fn_signed && fn_div && src_a[WIDTH-1];
      div0   <= fn_div && (src_b == '0);
    end
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .div_mode (core_div),
    .clear    (core_clear),
    .load_lo  (load_lo),
    .load_b   (load_b),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .last     (core_last)
  );

  // Remainder follows the dividend's sign; negating |x| restores x for a zero divisor too.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -acc_lo : acc_lo;
    if (div0) quo = '1;
    rem    = neg_r ? -acc_hi : acc_hi;
    fix_hi = op_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_div ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (write_hilo) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

  always_comb begin
    mf_result = '0;
    if (MD_ON && r_type && function_bits == FN_MFHI)      mf_result = hi;
    else if (MD_ON && r_type && function_bits == FN_MFLO) mf_result = lo;
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode table, mult/div results, busy stall, flush and async reset.
module tb_alu_control_md;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   alu_op = ALU_OP_MEM;
  logic [5:0]   function_bits = FN_ADD;
  logic         instr_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [2:0]   alu_operation;
  logic         is_jr;
  logic         stall;
  logic [W-1:0] mf_result;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  md_state_e    dbg_state;

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  alu_control_md #(.WIDTH(W), .ENABLE_MD(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op        (alu_op),
    .function_bits (function_bits),
    .instr_valid   (instr_valid),
    .flush         (flush),
    .src_a         (src_a),
    .src_b         (src_b),
    .alu_operation (alu_operation),
    .is_jr         (is_jr),
    .stall         (stall),
    .mf_result     (mf_result),
    .hi            (hi),
    .lo            (lo),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare: pops the oldest expectation
  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] want;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      want = exp_q.pop_front();
      assert (obs === want) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
    end
  endtask

  // Driver: new inputs 1 time unit after the rising edge, sampled 1 unit later.
  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    alu_op        = op;
    function_bits = fn;
    instr_valid   = v;
    src_a         = a;
    src_b         = b;
    #1;
  endtask

  task automatic idle();
    drive(ALU_OP_MEM, FN_ADD, 1'b0, '0, '0);
  endtask

  // Issue an md op, run n_indep independent adds, then a dependent mflo until it unstalls.
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int n_indep);
    int n;
    drive(ALU_OP_R, fn, 1'b1, a, b);
    exp_q.push_back('0);
    for (int k = 0; k < n_indep; k++) begin
      exp_q.push_back('0);
      exp_q.push_back(W'(ALU_ADD));
    end
    exp_q.push_back(W'(W + 1 - n_indep));
    exp_q.push_back(exp_lo);
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    check({tag, "_accept_stall"}, W'(stall));
    for (int k = 0; k < n_indep; k++) begin
      drive(ALU_OP_R, FN_ADD, 1'b1, 32'd1, 32'd2);
      check({tag, "_busy_add_stall"}, W'(stall));
      check({tag, "_busy_add_op"}, W'(alu_operation));
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      drive(ALU_OP_R, FN_MFLO, 1'b1, '0, '0);
      if (!stall) break;
      n++;
    end
    check({tag, "_stall_cycles"}, W'(n));
    check({tag, "_mflo"}, mf_result);
    check({tag, "_hi"}, hi);
    check({tag, "_lo"}, lo);
    idle();
  endtask

  logic [1:0] d_op[11]  = '{ALU_OP_R, ALU_OP_R, ALU_OP_R, ALU_OP_MEM, ALU_OP_BR, ALU_OP_SLTI,
                             ALU_OP_R, ALU_OP_R, ALU_OP_R, ALU_OP_R, ALU_OP_R};
  logic [5:0] d_fn[11]  = '{FN_ADD, FN_AND, FN_JR, FN_JR, FN_ADD, FN_ADD,
                             FN_SUB, FN_OR, FN_SLT, 6'b000011, FN_MULT};
  logic [2:0] d_exp[11] = '{3'b010, 3'b000, 3'b111, 3'b010, 3'b110, 3'b111,
                             3'b110, 3'b001, 3'b111, 3'b000, 3'b000};
  logic       d_jr[11]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [W-1:0]        ra, rb;
    logic [2*W-1:0]      up;
    logic signed [2*W-1:0] sp;

    // Reset state
    #3;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back(W'(ST_IDLE));
    check("reset_hi", hi);
    check("reset_lo", lo);
    check("reset_stall", W'(stall));
    check("reset_state", W'(dbg_state));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Decode table (includes an md funct on the ALU path and an unknown funct)
    for (int i = 0; i < 11; i++) begin
      drive(d_op[i], d_fn[i], 1'b0, '0, '0);
      exp_q.push_back(W'(d_exp[i]));
      exp_q.push_back(W'(d_jr[i]));
      exp_q.push_back('0);
      check($sformatf("decode%0d_op", i), W'(alu_operation));
      check($sformatf("decode%0d_jr", i), W'(is_jr));
      check($sformatf("decode%0d_stall", i), W'(stall));
    end

    // Directed mult/div including boundaries
    run_md("mult_7_m3", FN_MULT, 32'd7, -32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_md("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 3);
    run_md("div_m7_2", FN_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_md("div_5_0", FN_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    run_md("div_min_m1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run_md("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);

    // Random unsigned/signed against a wide-arithmetic model
    for (int i = 0; i < 2; i++) begin
      ra = $urandom;
      rb = $urandom;
      up = {32'd0, ra} * {32'd0, rb};
      run_md($sformatf("rnd_multu%0d", i), FN_MULTU, ra, rb, up[2*W-1:W], up[W-1:0], 0);
      sp = $signed({{W{ra[W-1]}}, ra}) * $signed({{W{rb[W-1]}}, rb});
      run_md($sformatf("rnd_mult%0d", i), FN_MULT, ra, rb, sp[2*W-1:W], sp[W-1:0], 0);
      rb = W'($urandom_range(1, 1000));
      run_md($sformatf("rnd_divu%0d", i), FN_DIVU, ra, rb, ra % rb, ra / rb, 1);
    end

    // Flush mid-multiply leaves HI/LO alone
    run_md("divu_3_2", FN_DIVU, 32'd3, 32'd2, 32'd1, 32'd1, 0);
    drive(ALU_OP_R, FN_MULT, 1'b1, 32'd3, 32'd4);
    repeat (5) idle();
    @(posedge clk);
    #1;
    flush       = 1'b1;
    instr_valid = 1'b0;
    #1;
    drive(ALU_OP_R, FN_MFHI, 1'b1, '0, '0);
    exp_q.push_back(W'(ST_IDLE)); exp_q.push_back('0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    check("flush_state", W'(dbg_state));
    check("flush_mfhi_stall", W'(stall));
    check("flush_mfhi", mf_result);
    check("flush_hi", hi);
    check("flush_lo", lo);
    repeat (40) idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    check("flush_hi_later", hi);
    check("flush_lo_later", lo);

    // Asynchronous reset in the middle of a divu
    drive(ALU_OP_R, FN_DIVU, 1'b1, 32'd100, 32'd7);
    repeat (11) drive(ALU_OP_R, FN_MFLO, 1'b1, '0, '0);
    exp_q.push_back(32'd1);
    check("pre_reset_stall", W'(stall));
    #1;
    rst = 1'b0;
    #1;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back(W'(ST_IDLE));
    check("async_rst_hi", hi);
    check("async_rst_lo", lo);
    check("async_rst_stall", W'(stall));
    check("async_rst_state", W'(dbg_state));
    @(negedge clk);
    rst = 1'b1;
    idle();
    run_md("post_rst_divu", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    // Final report
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
